coil_timer_master: RTL

Avalon-MM master that drives the interval timer's 16-bit register slave on behalf of coil-driver sequencing logic. It turns single-cycle commands into the required bus sequences: load period and start, stop, snapshot read, and status clear. It also services the timer interrupt by clearing the timeout flag and emitting a one-cycle event pulse. It sits between the coil pulse sequencer and the timer instance, so no soft CPU is needed in the timing path.

---
 rtl/coil_timer_master.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/coil_timer_master.sv
// ============================================================================
// coil_timer_master: Avalon-MM master sequencing the interval timer's 16-bit
// register slave for the coil sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

module coil_timer_master #(
  parameter logic IRQ_ENABLE = 1'b1,
  parameter logic AUTO_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        timeout_pulse,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        irq
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL_START, WR_CTL_STOP, WR_SNAP,
    RD_SL, RD_SH, RD_WAIT, WR_STAT, CLR_IRQ, RESP
  } state_t;

  state_t      state, state_n;
  logic        shadow_cont, shadow_cont_n;
  logic [15:0] period_hi, period_hi_n;
  logic [15:0] snap_lo, snap_lo_n;
  logic        cs_n, wn_n, rsp_valid_n, pulse_n;
  logic [2:0]  addr_n;
  logic [15:0] wdata_n;
  logic [31:0] rsp_data_n;

  assign cmd_ready = (state == IDLE) && !(AUTO_CLEAR && irq);

  // Bus outputs are computed for the next state so they register alongside it.
  always_comb begin
    state_n       = state;
    shadow_cont_n = shadow_cont;
    period_hi_n   = period_hi;
    snap_lo_n     = snap_lo;
    cs_n          = 1'b0;
    wn_n          = 1'b1;
    addr_n        = 3'd0;
    wdata_n       = 16'h0000;
    rsp_valid_n   = 1'b0;
    pulse_n       = 1'b0;
    rsp_data_n    = rsp_data;
    case (state)
      IDLE: begin
        if (AUTO_CLEAR && irq) begin
          state_n = CLR_IRQ;
          cs_n    = 1'b1;
          wn_n    = 1'b0;
          pulse_n = 1'b1;
        end else if (cmd_valid) begin
          cs_n = 1'b1;
          wn_n = 1'b0;
          case (cmd_op)
            2'd0: begin
              state_n       = WR_PL;
              addr_n        = 3'd2;
              wdata_n       = cmd_period[15:0];
              period_hi_n   = cmd_period[31:16];
              shadow_cont_n = cmd_continuous;
            end
            2'd1: begin
              state_n = WR_CTL_STOP;
              addr_n  = 3'd1;
              wdata_n = {12'd0, 1'b1, 1'b0, shadow_cont, IRQ_ENABLE};
            end
            2'd2: begin
              state_n = WR_SNAP;
              addr_n  = 3'd4;
            end
            default: state_n = WR_STAT;
          endcase
        end
      end
      WR_PL: begin
        state_n = WR_PH;
        cs_n    = 1'b1;
        wn_n    = 1'b0;
        addr_n  = 3'd3;
        wdata_n = period_hi;
      end
      WR_PH: begin
        state_n = WR_CTL_START;
        cs_n    = 1'b1;
        wn_n    = 1'b0;
        addr_n  = 3'd1;
        wdata_n = {12'd0, 1'b0, 1'b1, shadow_cont, IRQ_ENABLE};
      end
      WR_CTL_START, WR_CTL_STOP, WR_STAT: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
        rsp_data_n  = 32'd0;
      end
      WR_SNAP: begin
        state_n = RD_SL;
        cs_n    = 1'b1;
        addr_n  = 3'd4;
      end
      RD_SL: begin
        state_n = RD_SH;
        cs_n    = 1'b1;
        addr_n  = 3'd5;
      end
      // Slave read data lags the address by one cycle.
      RD_SH: begin
        state_n   = RD_WAIT;
        snap_lo_n = avm_readdata;
      end
      RD_WAIT: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
        rsp_data_n  = {avm_readdata, snap_lo};
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      shadow_cont    <= 1'b0;
      period_hi      <= 16'h0000;
      snap_lo        <= 16'h0000;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 3'd0;
      avm_writedata  <= 16'h0000;
      rsp_valid      <= 1'b0;
      rsp_data       <= 32'd0;
      timeout_pulse  <= 1'b0;
    end else begin
      state          <= state_n;
      shadow_cont    <= shadow_cont_n;
      period_hi      <= period_hi_n;
      snap_lo        <= snap_lo_n;
      avm_chipselect <= cs_n;
      avm_write_n    <= wn_n;
      avm_address    <= addr_n;
      avm_writedata  <= wdata_n;
      rsp_valid      <= rsp_valid_n;
      rsp_data       <= rsp_data_n;
      timeout_pulse  <= pulse_n;
    end
  end

endmodule

`default_nettype wire
